guest_entry_ctrl: RTL
=====================

# guest_entry_ctrl

Clocked controller for guest-vehicle admission, sitting directly upstream of guest exit handling and sharing the guest slot pool with it. Accepts entry requests from the gate sensor, allocates the lowest-numbered free guest slot, drives the entry barrier, and commits or rolls back the reservation depending on whether the car actually passes. Also consumes slot-release events from the exit stage so the free-slot count stays coherent.

## Interface
- N_GUEST, default `guest_slots` (20): number of guest slots; legal range 1..64.
- GATE_CYCLES, default 16: maximum cycles the barrier stays open waiting for car_pass; legal range ≥2.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- entry_req  in  1  level; car waiting at entry.
- car_pass  in  1  single-cycle pulse; barrier sensor saw the car go through.
- exit_valid  in  1  single-cycle pulse from exit stage; frees exit_slot.
- exit_slot  in  SW=$clog2(N_GUEST)  slot being vacated.
- entry_grant  out  1  one-cycle pulse; slot reserved.
- entry_deny  out  1  one-cycle pulse; pool full.
- slot_id  out  SW  allocated slot; valid from grant until return to IDLE.
- gate_open  out  1  barrier drive.
- entry_timeout  out  1  one-cycle pulse; reservation rolled back.
- exit_err  out  1  one-cycle pulse; exit_slot was already free.
- free_cnt  out  CW=$clog2(N_GUEST+1)  free slots.
- full  out  1  free_cnt == 0.

## Operation
- State: occupancy bitmap occ[N_GUEST-1:0], free_cnt, gate timer, FSM {IDLE, GATE, CLEAR}.
- IDLE: on entry_req=1: if free_cnt>0, reserve lowest index i with occ[i]=0, set occ[i], decrement free_cnt, pulse entry_grant, slot_id=i, go GATE; else pulse entry_deny, go CLEAR.
- GATE: gate_open=1, timer counts up from 0. car_pass → commit (occ unchanged), go CLEAR. Timer reaches GATE_CYCLES-1 with no car_pass → clear occ[slot_id], increment free_cnt, pulse entry_timeout, go CLEAR. car_pass on the final timer cycle wins (commit).
- CLEAR: gate_open=0; wait for entry_req=0, then IDLE. Prevents one waiting car from generating repeated grants/denies.
- Exit path, independent of FSM: exit_valid with occ[exit_slot]=1 → clear bit, increment free_cnt. occ[exit_slot]=0 or exit_slot≥N_GUEST → exit_err, no state change.
- Same-cycle entry allocation and exit release: allocation searches the pre-release bitmap; both updates apply; free_cnt net change 0. Exit of a slot freed in the same cycle by timeout → exit_err.
- free_cnt never wraps: checks above guarantee 0 ≤ free_cnt ≤ N_GUEST.

## Timing
- Reset (async, rst_n=0): occ=0, free_cnt=N_GUEST, full=0, FSM=IDLE, timer=0, slot_id=0, all pulses and gate_open =0. Reset mid-GATE drops the barrier immediately and discards the reservation.
- entry_req sampled high in IDLE at edge k → grant/deny, slot_id, free_cnt update visible after edge k (1-cycle latency); gate_open high from edge k through the edge leaving GATE.
- Barrier open at most GATE_CYCLES cycles.
- exit_valid at edge k → free_cnt/full/exit_err updated after edge k.
- All outputs registered; no combinational input-to-output paths.

## Structure
- Shared package/include alongside `guest_slots`: FSM state encoding, SW/CW width helpers, GATE_CYCLES default.
- One sub-module: guest_slot_picker, combinational lowest-zero priority encoder over occ, returning index plus any_free.

## Test plan
- N_GUEST=4, GATE_CYCLES=8: reset, then 4 req/car_pass cycles → slot_id 0,1,2,3, free_cnt 3→0, full=1; 5th req → entry_deny, free_cnt stays 0.
- Grant slot 0, no car_pass → gate_open high exactly 8 cycles, entry_timeout pulse, free_cnt back to 4, next grant reuses slot 0.
- occ={0,1,2}, exit_valid slot 1 → free_cnt 1→2; next grant returns slot_id 1.
- exit_valid slot 3 while free → exit_err=1, free_cnt unchanged.
- Pool full, exit_valid slot 2 in the same cycle as entry_req → entry_deny (pre-release bitmap), free_cnt ends at 1.
- rst_n low mid-GATE → gate_open=0 immediately, free_cnt=4, FSM IDLE; entry_req held high through the request → exactly one grant.

Source files
------------

// File: rtl/guest_entry_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// guest_entry_ctrl_pkg
// Shared definitions for the guest admission slice: default pool size
// (guest_slots), default barrier window, FSM state encoding and the width
// helpers used to size slot indices and free-slot counters.
// -----------------------------------------------------------------------------
package guest_entry_ctrl_pkg;

  // Default number of guest slots shared between entry and exit handling.
  localparam int guest_slots = 20;

  // Default maximum number of cycles the barrier stays open.
  localparam int GATE_CYCLES_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GATE  = 2'd1,
    S_CLEAR = 2'd2
  } state_e;

  // Slot index width; a single-slot pool still needs a 1-bit index port.
  function automatic int sw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold 0..n inclusive.
  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/guest_entry_ctrl_if.sv
// -----------------------------------------------------------------------------
// guest_entry_ctrl_if
// Bundles the sensor/exit-stage inputs and the admission outputs of
// guest_entry_ctrl.
//   master : drives entry_req, car_pass, exit_valid, exit_slot;
//            observes grant/deny/timeout/exit_err pulses, slot_id, gate_open,
//            free_cnt and full.
//   slave  : the controller side (directions reversed).
// -----------------------------------------------------------------------------
interface guest_entry_ctrl_if
  import guest_entry_ctrl_pkg::*;
#(
  parameter int N_GUEST = guest_slots
);

  localparam int SW = sw_of(N_GUEST);
  localparam int CW = cw_of(N_GUEST);

  logic          entry_req;
  logic          car_pass;
  logic          exit_valid;
  logic [SW-1:0] exit_slot;

  logic          entry_grant;
  logic          entry_deny;
  logic [SW-1:0] slot_id;
  logic          gate_open;
  logic          entry_timeout;
  logic          exit_err;
  logic [CW-1:0] free_cnt;
  logic          full;

  modport master (
    output entry_req, car_pass, exit_valid, exit_slot,
    input  entry_grant, entry_deny, slot_id, gate_open,
           entry_timeout, exit_err, free_cnt, full
  );

  modport slave (
    input  entry_req, car_pass, exit_valid, exit_slot,
    output entry_grant, entry_deny, slot_id, gate_open,
           entry_timeout, exit_err, free_cnt, full
  );

endinterface

// File: rtl/guest_slot_picker.sv
// -----------------------------------------------------------------------------
// guest_slot_picker
// Combinational lowest-zero priority encoder over the occupancy bitmap.
//   occ      : occupancy bitmap, bit i set = slot i in use
//   idx      : lowest index with occ[i] == 0 (0 when none free)
//   any_free : at least one slot is free
// -----------------------------------------------------------------------------
module guest_slot_picker
  import guest_entry_ctrl_pkg::*;
#(
  parameter int N_GUEST = guest_slots
) (
  input  logic [N_GUEST-1:0]          occ,
  output logic [sw_of(N_GUEST)-1:0]   idx,
  output logic                        any_free
);

  localparam int SW = sw_of(N_GUEST);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    // Scan high-to-low so the last hit written is the lowest free index.
    for (int i = N_GUEST - 1; i >= 0; i--) begin
      if (!occ[i]) begin
        idx      = SW'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/guest_entry_ctrl.sv
// -----------------------------------------------------------------------------
// guest_entry_ctrl
// Guest-vehicle admission controller. Reserves the lowest free guest slot on
// an entry request, opens the barrier for up to GATE_CYCLES cycles, commits
// on car_pass or rolls the reservation back on timeout, and absorbs slot
// releases from the exit stage so free_cnt stays coherent with the bitmap.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : guest_entry_ctrl_if.slave (requests, exit releases, all outputs)
// All outputs are registered.
// -----------------------------------------------------------------------------
module guest_entry_ctrl
  import guest_entry_ctrl_pkg::*;
#(
  parameter int N_GUEST     = guest_slots,
  parameter int GATE_CYCLES = GATE_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  guest_entry_ctrl_if.slave  bus
);

  localparam int SW = sw_of(N_GUEST);
  localparam int CW = cw_of(N_GUEST);
  localparam int TW = $clog2(GATE_CYCLES);

  localparam logic [TW-1:0] TIMER_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] FREE_INIT  = CW'(N_GUEST);
  localparam logic [SW:0]   SLOT_LIMIT = (SW + 1)'(N_GUEST);

  state_e               state;
  logic [N_GUEST-1:0]   occ;
  logic [N_GUEST-1:0]   occ_next;
  logic [CW-1:0]        free_next;
  logic [TW-1:0]        timer;

  logic [SW-1:0]        pick_idx;
  logic                 pick_any;

  logic                 idle_req;
  logic                 do_alloc;
  logic                 do_deny;
  logic                 do_timeout;
  logic                 timeout_rel;
  logic                 exit_in_range;
  logic                 exit_bit;
  logic                 exit_hit;
  logic                 exit_bad;

  // Allocation always searches the bitmap as it stood before this cycle's
  // releases, so a slot freed this cycle is never handed out in the same cycle.
  guest_slot_picker #(
    .N_GUEST (N_GUEST)
  ) u_picker (
    .occ      (occ),
    .idx      (pick_idx),
    .any_free (pick_any)
  );

  always_comb begin
    idle_req    = (state == S_IDLE) && bus.entry_req;
    do_alloc    = idle_req && (bus.free_cnt != '0) && pick_any;
    do_deny     = idle_req && !do_alloc;
    // car_pass on the last timer cycle wins, so it masks the timeout.
    do_timeout  = (state == S_GATE) && !bus.car_pass && (timer == TIMER_LAST);
    // Only give the slot back if it is still held; an exit that already
    // released the reserved slot must not be counted twice.
    timeout_rel = do_timeout && occ[bus.slot_id];

    exit_in_range = ({1'b0, bus.exit_slot} < SLOT_LIMIT);
    exit_bit      = 1'b0;
    if (exit_in_range) exit_bit = occ[bus.exit_slot];
    // A slot being rolled back by timeout this cycle counts as already free.
    exit_hit = bus.exit_valid && exit_bit &&
               !(do_timeout && (bus.exit_slot == bus.slot_id));
    exit_bad = bus.exit_valid && !exit_hit;

    occ_next = occ;
    if (do_alloc)    occ_next[pick_idx]      = 1'b1;
    if (timeout_rel) occ_next[bus.slot_id]   = 1'b0;
    if (exit_hit)    occ_next[bus.exit_slot] = 1'b0;

    free_next = bus.free_cnt - CW'(do_alloc) + CW'(timeout_rel) + CW'(exit_hit);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above, regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      // NOTE: occ is a flop bitmap rather than a RAM, so it is reset here;
      // an unreset pool would hand out arbitrary slots after power-up.
      occ               <= '0;
      timer             <= '0;
      bus.free_cnt      <= FREE_INIT;
      bus.full          <= 1'b0;
      bus.slot_id       <= '0;
      bus.gate_open     <= 1'b0;
      bus.entry_grant   <= 1'b0;
      bus.entry_deny    <= 1'b0;
      bus.entry_timeout <= 1'b0;
      bus.exit_err      <= 1'b0;
    end else begin
      occ               <= occ_next;
      bus.free_cnt      <= free_next;
      bus.full          <= (free_next == '0);
      bus.entry_grant   <= do_alloc;
      bus.entry_deny    <= do_deny;
      bus.entry_timeout <= do_timeout;
      bus.exit_err      <= exit_bad;

      case (state)
        S_IDLE: begin
          if (do_alloc) begin
            bus.slot_id   <= pick_idx;
            timer         <= '0;
            bus.gate_open <= 1'b1;
            state         <= S_GATE;
          end else if (do_deny) begin
            state <= S_CLEAR;
          end
        end
        S_GATE: begin
          if (bus.car_pass || do_timeout) begin
            bus.gate_open <= 1'b0;
            state         <= S_CLEAR;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_CLEAR: begin
          // Hold off until the car leaves the sensor so one waiting car
          // produces exactly one grant or deny.
          if (!bus.entry_req) state <= S_IDLE;
        end
        default: begin
          bus.gate_open <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule
